// File: rtl/wb4_bram_pkg.sv
// wb4_bram_pkg: shared definitions for the wb4_bram slave.
// Holds the FSM state encoding and the ceil-log2 helper used for address decode.
package wb4_bram_pkg;

   typedef enum logic {
      WB4_BRAM_INIT  = 1'b0,
      WB4_BRAM_READY = 1'b1
   } wb4_bram_state_e;

   // Ceiling log2, usable in parameter/localparam expressions; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return res;
   endfunction

   // Number of byte-offset bits below the word index.
   function automatic int unsigned clog2_archbitsz_by8(input int unsigned archbitsz);
      return clog2(archbitsz / 8);
   endfunction

endpackage

// File: rtl/wb4_bram_mem.sv
// wb4_bram_mem: single-port RAM, per-byte write enable, registered read.
// No reset on the array or the read register so it maps onto block RAM.
module wb4_bram_mem
   import wb4_bram_pkg::*;
#(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = clog2(DEPTH)
) (
   input  logic            clk,
   input  logic [AW-1:0]   addr,
   input  logic [DW/8-1:0] be,
   input  logic [DW-1:0]   wdata,
   input  logic            re,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] mem [DEPTH];

   // Byte-lane writes and registered read share one address port.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < DW/8; k++) begin
         if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/wb4_bram.sv
// wb4_bram: Wishbone B4 pipelined slave in front of a byte-writable block RAM.
// One request per cycle, one ack per accepted request one cycle later.
// Optional macro WB4_BRAM_CLRONRST_EN: clear the whole array after reset,
// stalling the bus for SIZE cycles while the sweep runs.
module wb4_bram
   import wb4_bram_pkg::*;
#(
   parameter int unsigned ARCHBITSZ = 16,
   parameter int unsigned SIZE      = 4096
) (
   input  logic                   wb4_clk_i,
   input  logic                   wb4_rst_i,
   input  logic                   wb4_cyc_i,
   input  logic                   wb4_stb_i,
   input  logic                   wb4_we_i,
   input  logic [ARCHBITSZ-1:0]   wb4_addr_i,
   input  logic [ARCHBITSZ-1:0]   wb4_data_i,
   input  logic [ARCHBITSZ/8-1:0] wb4_sel_i,
   output logic                   wb4_stall_o,
   output logic                   wb4_ack_o,
   output logic [ARCHBITSZ-1:0]   wb4_data_o
);

   localparam int unsigned CLOG2ARCHBITSZBY8 = clog2_archbitsz_by8(ARCHBITSZ);
   localparam int unsigned AW                = clog2(SIZE);
   localparam int unsigned NB                = ARCHBITSZ / 8;

   logic [AW-1:0]        idx;
   logic                 accept;
   logic                 ackq;
   logic                 rdq;
   logic [AW-1:0]        mem_addr;
   logic [NB-1:0]        mem_be;
   logic [ARCHBITSZ-1:0] mem_wdata;
   logic                 mem_re;
   logic [ARCHBITSZ-1:0] mem_rdata;

   // Drop byte-offset bits, then truncate: upper address bits alias modulo SIZE.
   assign idx    = AW'(wb4_addr_i >> CLOG2ARCHBITSZBY8);
   assign accept = wb4_cyc_i & wb4_stb_i & ~wb4_stall_o;

`ifdef WB4_BRAM_CLRONRST_EN
   wb4_bram_state_e state, state_nxt;
   logic [AW-1:0]   clr_cnt, clr_cnt_nxt;

   assign wb4_stall_o = (state == WB4_BRAM_INIT);

   // State and clear-counter registers; every reset restarts the sweep at word 0.
   always_ff @(posedge wb4_clk_i or negedge wb4_rst_i) begin
      if (!wb4_rst_i) begin
         state   <= WB4_BRAM_INIT;
         clr_cnt <= '0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
      end
   end

   // Next state and RAM port mux: the sweep owns the port while in INIT.
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      mem_addr    = idx;
      mem_be      = (accept & wb4_we_i) ? wb4_sel_i : '0;
      mem_wdata   = wb4_data_i;
      mem_re      = accept & ~wb4_we_i;
      if (state == WB4_BRAM_INIT) begin
         mem_addr    = clr_cnt;
         mem_be      = '1;
         mem_wdata   = '0;
         mem_re      = 1'b0;
         clr_cnt_nxt = clr_cnt + AW'(1);
         if (clr_cnt == AW'(SIZE - 1)) state_nxt = WB4_BRAM_READY;
      end
   end
`else
   assign wb4_stall_o = 1'b0;

   // RAM port driven straight from the accepted bus request.
   always_comb begin
      mem_addr  = idx;
      mem_be    = (accept & wb4_we_i) ? wb4_sel_i : '0;
      mem_wdata = wb4_data_i;
      mem_re    = accept & ~wb4_we_i;
   end
`endif

   // Ack pending flag and read flag for the request accepted last cycle.
   always_ff @(posedge wb4_clk_i or negedge wb4_rst_i) begin
      if (!wb4_rst_i) begin
         ackq <= 1'b0;
         rdq  <= 1'b0;
      end else begin
         ackq <= accept;
         rdq  <= accept & ~wb4_we_i;
      end
   end

   // Dropping cyc cancels a pending ack; data is zero unless a read is being acked.
   assign wb4_ack_o  = ackq & wb4_cyc_i;
   assign wb4_data_o = (wb4_ack_o & rdq) ? mem_rdata : '0;

   wb4_bram_mem #(
      .DW    (ARCHBITSZ),
      .DEPTH (SIZE),
      .AW    (AW)
   ) u_mem (
      .clk   (wb4_clk_i),
      .addr  (mem_addr),
      .be    (mem_be),
      .wdata (mem_wdata),
      .re    (mem_re),
      .rdata (mem_rdata)
   );

endmodule
